// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO and result slot in front of a combinational ALU
// Optional feature macro: ALU_ISSUE_FWD_EN (A taken from the last result when the head entry has fwd set)
module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_A,
    input  logic [WIDTH-1:0]         in_B,
    input  logic [3:0]               in_opcode,
    input  logic                     in_fwd,
    output logic [WIDTH-1:0]         A,
    output logic [WIDTH-1:0]         B,
    output logic [3:0]               opcode,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_opcode,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [3:0]       r_mem_op [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [3:0]       r_out_opcode;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_issue;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // in_ready looks only at registered occupancy: a pop in the same cycle does not open a slot
    assign w_push  = in_valid && !w_full;
    assign w_issue = !w_empty && (!r_out_valid || out_ready);

`ifdef ALU_ISSUE_FWD_EN
    logic             r_mem_fwd [DEPTH];
    logic [WIDTH-1:0] r_last_result;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_fwd[r_wr_ptr] <= in_fwd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_result <= '0;
        end else if (w_issue) begin
            r_last_result <= alu_result;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = in_fwd;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_A;
            r_mem_b[r_wr_ptr]  <= in_B;
            r_mem_op[r_wr_ptr] <= in_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head drives the ALU directly; an empty FIFO presents zeros, never the live inputs
    always_comb begin
        A      = '0;
        B      = '0;
        opcode = '0;
        if (!w_empty) begin
            A      = r_mem_a[r_rd_ptr];
`ifdef ALU_ISSUE_FWD_EN
            if (r_mem_fwd[r_rd_ptr]) begin
                A = r_last_result;
            end
`endif
            B      = r_mem_b[r_rd_ptr];
            opcode = r_mem_op[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_opcode <= '0;
        end else if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_opcode <= r_mem_op[r_rd_ptr];
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_opcode = r_out_opcode;
    assign occupancy  = r_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed bench for alu_issue_stage against a queue model
module tb_alu_issue_stage;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_A = '0;
    logic [15:0] in_B = '0;
    logic [3:0]  in_opcode = '0;
    logic        in_fwd = 1'b0;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_opcode;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode), .in_fwd(in_fwd),
        .A(A), .B(B), .opcode(opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .occupancy(occupancy)
    );

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return ~a + {12'd0, op};
        endcase
    endfunction

    assign alu_result = alu_f(A, B, opcode);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        fwd;
    } cmd_t;

    cmd_t        q[$];
    bit          m_valid;
    logic [15:0] m_res;
    logic [3:0]  m_op;
    logic [15:0] m_last;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_valid = 0;
        m_res   = '0;
        m_op    = '0;
        m_last  = '0;
    endfunction

    function automatic logic [15:0] exp_a();
        if (q.size() == 0) return '0;
`ifdef ALU_ISSUE_FWD_EN
        if (q[0].fwd) return m_last;
`endif
        return q[0].a;
    endfunction

    function automatic void model_edge();
        bit   push;
        bit   issue;
        cmd_t c;
        push  = in_valid && (q.size() < DEPTH);
        issue = (q.size() > 0) && (!m_valid || out_ready);
        if (issue) begin
            m_res   = alu_f(exp_a(), q[0].b, q[0].op);
            m_op    = q[0].op;
            m_last  = m_res;
            m_valid = 1;
            void'(q.pop_front());
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (push) begin
            c.a = in_A; c.b = in_B; c.op = in_opcode; c.fwd = in_fwd;
            q.push_back(c);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid",  {31'd0, out_valid}, {31'd0, m_valid});
            chk("out_result", {16'd0, out_result}, {16'd0, m_res});
            chk("out_opcode", {28'd0, out_opcode}, {28'd0, m_op});
            chk("occupancy",  {29'd0, occupancy}, q.size());
            chk("in_ready",   {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
            chk("alu_A",      {16'd0, A}, {16'd0, exp_a()});
            chk("alu_B",      {16'd0, B}, (q.size() > 0) ? {16'd0, q[0].b} : 32'd0);
            chk("alu_op",     {28'd0, opcode}, (q.size() > 0) ? {28'd0, q[0].op} : 32'd0);
        end
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic f);
        in_valid = v; in_A = a; in_B = b; in_opcode = op; in_fwd = f;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (occupancy == 0 && !out_valid) break;
            step();
        end
        chk("drain", {31'd0, (occupancy == 0 && !out_valid)}, 32'd1);
    endtask

    logic [15:0] got[$];
    bit          acc;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_occ",       {29'd0, occupancy}, 32'd0);
        chk("rst_A",         {16'd0, A}, 32'd0);
        chk("rst_result",    {16'd0, out_result}, 32'd0);

        // single ADD
        out_ready = 1'b1;
        drive(1, 16'd3, 16'd5, 4'd0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("add_latency", {31'd0, out_valid}, 32'd0);
        step();
        chk("add_valid",  {31'd0, out_valid}, 32'd1);
        chk("add_result", {16'd0, out_result}, 32'h0008);
        chk("add_opcode", {28'd0, out_opcode}, 32'd0);

        // SUB
        drain();
        drive(1, 16'd5, 16'd7, 4'd1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("sub_result", {16'd0, out_result}, 32'hFFFE);
        chk("sub_opcode", {28'd0, out_opcode}, 32'd1);

        // back-pressure, then full FIFO with simultaneous pop
        drain();
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            drive(1, 16'(n), 16'(n), 4'd0, 0);
            step();
        end
        drive(1, 16'd6, 16'd6, 4'd0, 0);
        step();
        chk("bp_occ",     {29'd0, occupancy}, 32'd4);
        chk("bp_ready",   {31'd0, in_ready}, 32'd0);
        chk("bp_held",    {16'd0, out_result}, 32'd2);
        got.delete();
        got.push_back(out_result);
        out_ready = 1'b1;
        step();
        chk("fullpop_occ",   {29'd0, occupancy}, 32'd3);
        chk("fullpop_ready", {31'd0, in_ready}, 32'd1);
        if (out_valid) got.push_back(out_result);
        for (int k = 0; k < 15 && got.size() < 6; k++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            if (out_valid) got.push_back(out_result);
        end
        chk("bp_count", got.size(), 32'd6);
        for (int i = 0; i < got.size(); i++) begin
            chk("bp_order", {16'd0, got[i]}, 32'(2 * (i + 1)));
        end

        // forwarding
        drain();
        drive(1, 16'd1, 16'd2, 4'd0, 0);
        step();
        drive(1, 16'd100, 16'd10, 4'd0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("fwd_first", {16'd0, out_result}, 32'd3);
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_A", {16'd0, A}, 32'd3);
        step();
        chk("fwd_second", {16'd0, out_result}, 32'd13);
`else
        chk("fwd_A", {16'd0, A}, 32'd100);
        step();
        chk("fwd_second", {16'd0, out_result}, 32'd110);
`endif

        // random traffic with a mid-stream reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                out_ready = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    drive(1, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
                    step();
                end
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                chk("mrst_valid",  {31'd0, out_valid}, 32'd0);
                chk("mrst_occ",    {29'd0, occupancy}, 32'd0);
                chk("mrst_ready",  {31'd0, in_ready}, 32'd1);
                chk("mrst_AB",     {A, B}, 32'd0);
                chk("mrst_op",     {28'd0, opcode}, 32'd0);
                chk("mrst_result", {16'd0, out_result}, 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive(0, 0, 0, 0, 0);
                out_ready = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);
                end
            end
            drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 4'($urandom % 8), 1'($urandom));
            out_ready = ((cyc / 200) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            step();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
